// File: rtl/control_unit_mc_if.sv
// control_unit_mc_if: IR fields and ALU/divider flags into the control FSM,
// every datapath select, write enable and strobe back out to the datapath.
interface control_unit_mc_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       overflow;
  logic       zero;
  logic       div0;

  logic       pc_write;
  logic [2:0] pc_src;
  logic       mem_wr;
  logic       ir_write;
  logic       mdr_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] wb_src;
  logic       alu_a;
  logic [1:0] alu_b;
  logic [2:0] alu_op;
  logic       aluout_write;
  logic       epc_write;
  logic [1:0] exc_cause;
  logic       md_start;
  logic       md_sel;
  logic       hilo_write;
  logic [3:0] state;

  modport master (
    input  opcode, funct, overflow, zero, div0,
    output pc_write, pc_src, mem_wr, ir_write, mdr_write, reg_write, reg_dst,
           wb_src, alu_a, alu_b, alu_op, aluout_write, epc_write, exc_cause,
           md_start, md_sel, hilo_write, state
  );

  modport slave (
    output opcode, funct, overflow, zero, div0,
    input  pc_write, pc_src, mem_wr, ir_write, mdr_write, reg_write, reg_dst,
           wb_src, alu_a, alu_b, alu_op, aluout_write, epc_write, exc_cause,
           md_start, md_sel, hilo_write, state
  );
endinterface

// File: rtl/control_unit_mc.sv
// control_unit_mc: multicycle MIPS-subset control FSM; define MULTDIV_EN to build mult/div sequencing.
// One state per cycle, controls registered on state entry; no backpressure, MD_WAIT stalls MD_CYCLES cycles.
module control_unit_mc #(
  parameter int MD_CYCLES = 32,
  parameter int SP_INIT   = 227
) (
  input  logic              clock,
  input  logic              reset,
  control_unit_mc_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_IRLOAD   = 4'd2,
    S_DECODE   = 4'd3,
    S_EXEC     = 4'd4,
    S_WB       = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WAIT = 4'd7,
    S_MD_WAIT  = 4'd8,
    S_EXC      = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    I_INV, I_ADD, I_SUB, I_AND, I_JR, I_MULT, I_DIV,
    I_ADDI, I_BEQ, I_BNE, I_LW, I_SW, I_LUI, I_J
  } ins_t;

  typedef struct packed {
    logic       pc_write;
    logic [2:0] pc_src;
    logic       mem_wr;
    logic       ir_write;
    logic       mdr_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic       alu_a;
    logic [1:0] alu_b;
    logic [2:0] alu_op;
    logic       aluout_write;
    logic       epc_write;
    logic [1:0] exc_cause;
  } ctl_t;

  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_AND    = 3'd3;
  localparam logic [2:0] PC_ALUOUT  = 3'd1;
  localparam logic [2:0] PC_JUMP    = 3'd2;
  localparam logic [2:0] PC_REGA    = 3'd3;
  localparam logic [2:0] PC_EXC     = 3'd4;
  localparam logic [1:0] CAUSE_INV  = 2'd0;
  localparam logic [1:0] CAUSE_OVF  = 2'd1;
  localparam logic [1:0] CAUSE_DIV0 = 2'd2;

  if (MD_CYCLES < 1 || SP_INIT < 0) begin : g_param_check
    $error("control_unit_mc: MD_CYCLES must be >= 1 and SP_INIT non-negative");
  end

  function automatic ins_t decode(input logic [5:0] op, input logic [5:0] fn);
    ins_t r;
    r = I_INV;
    case (op)
      6'h00: begin
        case (fn)
          6'h20:   r = I_ADD;
          6'h22:   r = I_SUB;
          6'h24:   r = I_AND;
          6'h08:   r = I_JR;
`ifdef MULTDIV_EN
          6'h18:   r = I_MULT;
          6'h1A:   r = I_DIV;
`endif
          default: r = I_INV;
        endcase
      end
      6'h08:   r = I_ADDI;
      6'h04:   r = I_BEQ;
      6'h05:   r = I_BNE;
      6'h23:   r = I_LW;
      6'h2B:   r = I_SW;
      6'h0F:   r = I_LUI;
      6'h02:   r = I_J;
      default: r = I_INV;
    endcase
    return r;
  endfunction

  // Controls that depend only on the state being entered and the decoded instruction.
  function automatic ctl_t ctl_for(input state_t s, input ins_t i, input logic [1:0] cause);
    ctl_t c;
    c = '0;
    case (s)
      S_RESET: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 2'd2;
        c.wb_src    = 2'd3;
      end
      S_FETCH: begin
        c.alu_b    = 2'd1;
        c.alu_op   = ALU_ADD;
        c.pc_write = 1'b1;
      end
      S_IRLOAD: c.ir_write = 1'b1;
      S_DECODE: begin
        c.alu_b        = 2'd3;
        c.alu_op       = ALU_ADD;
        c.aluout_write = 1'b1;
      end
      S_EXEC: begin
        case (i)
          I_ADD, I_SUB, I_AND: begin
            c.alu_a        = 1'b1;
            c.alu_op       = (i == I_ADD) ? ALU_ADD : (i == I_SUB) ? ALU_SUB : ALU_AND;
            c.aluout_write = 1'b1;
          end
          I_ADDI, I_LW, I_SW: begin
            c.alu_a        = 1'b1;
            c.alu_b        = 2'd2;
            c.alu_op       = ALU_ADD;
            c.aluout_write = 1'b1;
          end
          I_BEQ, I_BNE: begin
            c.alu_a  = 1'b1;
            c.alu_op = ALU_SUB;
            c.pc_src = PC_ALUOUT;
          end
          I_JR: begin
            c.pc_src   = PC_REGA;
            c.pc_write = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM_RD:   c.mem_wr    = (i == I_SW);
      S_MEM_WAIT: c.mdr_write = 1'b1;
      S_WB: begin
        c.reg_write = 1'b1;
        case (i)
          I_ADDI:  c.reg_dst = 2'd1;
          I_LW: begin
            c.reg_dst = 2'd1;
            c.wb_src  = 2'd1;
          end
          I_LUI: begin
            c.reg_dst = 2'd1;
            c.wb_src  = 2'd2;
          end
          default: ;
        endcase
      end
      S_EXC: begin
        c.alu_b     = 2'd1;
        c.alu_op    = ALU_SUB;
        c.epc_write = 1'b1;
        c.pc_src    = PC_EXC;
        c.pc_write  = 1'b1;
        c.exc_cause = cause;
      end
      default: ;
    endcase
    return c;
  endfunction

  state_t     state, nxt;
  ins_t       ins_q, nxt_ins, dec_ins;
  logic [1:0] nxt_cause;
  ctl_t       ctl_q;

`ifdef MULTDIV_EN
  localparam int            CW      = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CW-1:0] MD_LOAD = CW'(MD_CYCLES - 1);
  logic [CW-1:0] md_cnt, nxt_cnt;
  logic          md_start_q, md_sel_q, hilo_q;
`endif

  always_comb begin
    dec_ins   = decode(bus.opcode, bus.funct);
    nxt       = state;
    nxt_ins   = ins_q;
    nxt_cause = CAUSE_INV;
`ifdef MULTDIV_EN
    nxt_cnt   = md_cnt;
`endif
    case (state)
      S_RESET:  nxt = S_FETCH;
      S_FETCH:  nxt = S_IRLOAD;
      S_IRLOAD: nxt = S_DECODE;
      S_DECODE: begin
        nxt_ins = dec_ins;
        if (dec_ins == I_INV) begin
          nxt       = S_EXC;
          nxt_cause = CAUSE_INV;
        end else if (dec_ins == I_J) begin
          nxt = S_FETCH;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (ins_q)
          I_ADD, I_SUB, I_ADDI: begin
            if (bus.overflow) begin
              nxt       = S_EXC;
              nxt_cause = CAUSE_OVF;
            end else begin
              nxt = S_WB;
            end
          end
          I_AND, I_LUI: nxt = S_WB;
          I_LW, I_SW:   nxt = S_MEM_RD;
`ifdef MULTDIV_EN
          I_MULT: begin
            nxt     = S_MD_WAIT;
            nxt_cnt = MD_LOAD;
          end
          I_DIV: begin
            if (bus.div0) begin
              nxt       = S_EXC;
              nxt_cause = CAUSE_DIV0;
            end else begin
              nxt     = S_MD_WAIT;
              nxt_cnt = MD_LOAD;
            end
          end
`endif
          default: nxt = S_FETCH;
        endcase
      end
      S_MEM_RD:   nxt = (ins_q == I_LW) ? S_MEM_WAIT : S_FETCH;
      S_MEM_WAIT: nxt = S_WB;
      S_WB:       nxt = S_FETCH;
      S_MD_WAIT: begin
`ifdef MULTDIV_EN
        if (md_cnt == '0) nxt = S_FETCH;
        else              nxt_cnt = md_cnt - CW'(1);
`else
        nxt = S_FETCH;
`endif
      end
      S_EXC:   nxt = S_FETCH;
      default: nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_RESET;
      ins_q      <= I_INV;
      ctl_q      <= ctl_for(S_RESET, I_INV, CAUSE_INV);
`ifdef MULTDIV_EN
      md_cnt     <= '0;
      md_start_q <= 1'b0;
      md_sel_q   <= 1'b0;
      hilo_q     <= 1'b0;
`endif
    end else begin
      state      <= nxt;
      ins_q      <= nxt_ins;
      ctl_q      <= ctl_for(nxt, nxt_ins, nxt_cause);
`ifdef MULTDIV_EN
      md_cnt     <= nxt_cnt;
      md_start_q <= (nxt == S_EXEC) && ((nxt_ins == I_MULT) || (nxt_ins == I_DIV));
      md_sel_q   <= (nxt == S_EXEC) && (nxt_ins == I_DIV);
      hilo_q     <= (nxt == S_MD_WAIT) && (nxt_cnt == '0);
`endif
    end
  end

  // Jump and branch PC loads depend on inputs valid only in the current cycle.
  logic j_now, br_taken;
  assign j_now    = (state == S_DECODE) && (dec_ins == I_J);
  assign br_taken = (state == S_EXEC) &&
                    (((ins_q == I_BEQ) && bus.zero) || ((ins_q == I_BNE) && !bus.zero));

  assign bus.pc_write     = ctl_q.pc_write | j_now | br_taken;
  assign bus.pc_src       = j_now ? PC_JUMP : ctl_q.pc_src;
  assign bus.mem_wr       = ctl_q.mem_wr;
  assign bus.ir_write     = ctl_q.ir_write;
  assign bus.mdr_write    = ctl_q.mdr_write;
  assign bus.reg_write    = ctl_q.reg_write & ~reset;
  assign bus.reg_dst      = ctl_q.reg_dst;
  assign bus.wb_src       = ctl_q.wb_src;
  assign bus.alu_a        = ctl_q.alu_a;
  assign bus.alu_b        = ctl_q.alu_b;
  assign bus.alu_op       = ctl_q.alu_op;
  assign bus.aluout_write = ctl_q.aluout_write;
  assign bus.epc_write    = ctl_q.epc_write;
  assign bus.exc_cause    = ctl_q.exc_cause;
  assign bus.state        = state;

`ifdef MULTDIV_EN
  // A zero divisor cancels the start pulse in the same EXEC cycle it is seen.
  logic div_fault;
  assign div_fault      = (state == S_EXEC) && (ins_q == I_DIV) && bus.div0;
  assign bus.md_start   = md_start_q & ~div_fault;
  assign bus.md_sel     = md_sel_q & ~div_fault;
  assign bus.hilo_write = hilo_q & ~reset;
`else
  logic unused_div0;
  assign unused_div0    = bus.div0;
  assign bus.md_start   = 1'b0;
  assign bus.md_sel     = 1'b0;
  assign bus.hilo_write = 1'b0;
`endif

endmodule
